// File: rtl/aes_block_shift_reg.sv
// aes_block_shift_reg
//
// WIDTH x DEPTH shift-register buffer that gathers a serial element stream
// into one parallel block (AES state assembly). With AES_SHIFT_REG_DRAIN_EN
// defined, it can also take a parallel block and serialise it back out.
//
// Optional feature macro: AES_SHIFT_REG_DRAIN_EN (parallel load + drain path).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous clear of contents, count and state
//   s_valid/s_ready   serial input handshake, element on s_data
//   p_valid/p_ready   parallel block output handshake, block on p_data
//   l_valid/l_ready   parallel load handshake, block on l_data
//   d_valid/d_ready   serial drain handshake, element on d_data
//   count             number of elements currently held
//
// Block packing: element i lives at [i*WIDTH +: WIDTH]; element 0 is the
// oldest serial element and the next one to be drained.
module aes_block_shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       p_valid,
  input  logic                       p_ready,
  output logic [WIDTH*DEPTH-1:0]     p_data,
  input  logic                       l_valid,
  output logic                       l_ready,
  input  logic [WIDTH*DEPTH-1:0]     l_data,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [WIDTH-1:0]           d_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic in_fill, empty;
  logic s_acc, l_acc, p_acc, d_acc;

  assign in_fill = (state_q == ST_FILL);
  assign empty   = (count_q == '0);

  // Handshake outputs are suppressed outright during reset or flush so no
  // transfer can be claimed in a cycle whose result is about to be discarded.
`ifdef AES_SHIFT_REG_DRAIN_EN
  assign s_ready = !rst && !flush && in_fill && !(empty && l_valid);
  assign l_ready = !rst && !flush && in_fill && empty;
  assign d_valid = !rst && !flush && (state_q == ST_DRAIN);
  assign d_data  = regs_q[0];
`else
  assign s_ready = !rst && !flush && in_fill;
  assign l_ready = 1'b0;
  assign d_valid = 1'b0;
  assign d_data  = '0;
  // Load/drain inputs have no function in this build.
  logic unused_drain_inputs;
  assign unused_drain_inputs = ^{l_valid, l_data, d_ready};
`endif
  assign p_valid = !rst && !flush && (state_q == ST_FULL);
  assign count   = count_q;

  assign s_acc = s_valid && s_ready;
  assign l_acc = l_valid && l_ready;
  assign p_acc = p_valid && p_ready;
  assign d_acc = d_valid && d_ready;

  always_comb begin
    p_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p_data[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end

    if (flush) begin
      state_d = ST_FILL;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_FILL: begin
          if (l_acc) begin
            // l_ready is only high at count 0, so a load always wins over a
            // simultaneous serial offer.
            for (int i = 0; i < DEPTH; i++) begin
              regs_d[i] = l_data[i*WIDTH +: WIDTH];
            end
            count_d = CW'(DEPTH);
            state_d = ST_DRAIN;
          end else if (s_acc) begin
            // New element enters at the top; after DEPTH accepts the first
            // element received has reached reg[0].
            for (int i = 0; i < DEPTH-1; i++) begin
              regs_d[i] = regs_q[i+1];
            end
            regs_d[DEPTH-1] = s_data;
            count_d = count_q + CW'(1);
            if (count_q == CW'(DEPTH-1)) begin
              state_d = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          // Contents are kept after hand-off; only the occupancy restarts.
          if (p_acc) begin
            count_d = '0;
            state_d = ST_FILL;
          end
        end
        ST_DRAIN: begin
          if (d_acc) begin
            for (int i = 0; i < DEPTH-1; i++) begin
              regs_d[i] = regs_q[i+1];
            end
            regs_d[DEPTH-1] = '0;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_d = ST_FILL;
            end
          end
        end
        default: begin
          state_d = ST_FILL;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_aes_block_shift_reg.sv
module tb_aes_block_shift_reg;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PW = W*D;
  localparam int CW = $clog2(D+1);
`ifdef AES_SHIFT_REG_DRAIN_EN
  localparam bit DRN = 1'b1;
`else
  localparam bit DRN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, s_valid, p_ready, l_valid, d_ready;
  logic [W-1:0]  s_data;
  logic [PW-1:0] l_data;
  logic          s_ready, p_valid, l_ready, d_valid;
  logic [PW-1:0] p_data;
  logic [W-1:0]  d_data;
  logic [CW-1:0] count;

  aes_block_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: elements held (front = oldest / next out) plus a mode.
  typedef enum int {M_FILL, M_FULL, M_DRAIN} mode_t;
  mode_t        mode;
  logic [W-1:0] q[$];
  int           cyc_no = 0;
  int           del_t[$];
  logic [PW-1:0] last_block;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic e_s_ready();
    return !rst && !flush && mode == M_FILL && !(DRN && q.size() == 0 && l_valid);
  endfunction
  function automatic logic e_l_ready();
    return DRN && !rst && !flush && mode == M_FILL && q.size() == 0;
  endfunction

  function automatic logic [PW-1:0] packq();
    logic [PW-1:0] r = '0;
    for (int i = 0; i < q.size(); i++) r[i*W +: W] = q[i];
    return r;
  endfunction

  // Entered 2 time units after a rising edge with inputs already driven.
  task automatic cyc();
    logic sr, lr;
    #1;
    sr = e_s_ready();
    lr = e_l_ready();
    chk("s_ready", s_ready, sr);
    chk("l_ready", l_ready, lr);
    chk("p_valid", p_valid, !rst && !flush && mode == M_FULL);
    chk("d_valid", d_valid, DRN && !rst && !flush && mode == M_DRAIN);
    chk("count", count, q.size());
    if (mode == M_FULL && !flush) chk("p_data", p_data, packq());
    if (mode == M_DRAIN && !flush) chk("d_data", d_data, q[0]);
    if (p_valid && p_ready) begin
      del_t.push_back(cyc_no);
      last_block = p_data;
    end
    if (flush) begin
      q.delete();
      mode = M_FILL;
    end else begin
      case (mode)
        M_FILL: begin
          if (l_valid && lr) begin
            q.delete();
            for (int i = 0; i < D; i++) q.push_back(l_data[i*W +: W]);
            mode = M_DRAIN;
          end else if (s_valid && sr) begin
            q.push_back(s_data);
            if (q.size() == D) mode = M_FULL;
          end
        end
        M_FULL: if (p_ready) begin q.delete(); mode = M_FILL; end
        M_DRAIN: if (d_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) mode = M_FILL;
        end
        default: mode = M_FILL;
      endcase
    end
    @(posedge clk);
    #2;
    cyc_no++;
  endtask

  task automatic idle_inputs();
    flush = 0; s_valid = 0; p_ready = 0; l_valid = 0; d_ready = 0;
    s_data = '0; l_data = '0;
  endtask

  initial begin
    logic [7:0]    nxt;
    logic [PW-1:0] blk;
    idle_inputs();
    mode = M_FILL;
    rst = 1;
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_l_ready", l_ready, 0);
    chk("rst_p_valid", p_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_p_data", p_data, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_count", count, 0);
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #2;

    // Serial fill 0x00..0x0F with no consumer.
    s_valid = 1;
    for (int i = 0; i < D; i++) begin
      s_data = 8'(i);
      cyc();
    end
    s_data = 8'hEE;
    #1;
    chk("fill_p_valid", p_valid, 1);
    chk("fill_p_data", p_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("fill_count", count, D);
    #1;
    for (int i = 0; i < 3; i++) cyc();

    // Two back-to-back blocks with p_ready held high.
    p_ready = 1;
    nxt = 8'h10;
    for (int i = 0; i < 60 && del_t.size() < 3; i++) begin
      s_data = nxt;
      if (e_s_ready()) nxt++;
      cyc();
    end
    chk("b2b_deliveries", del_t.size(), 3);
    if (del_t.size() >= 3) begin
      chk("b2b_period1", del_t[1] - del_t[0], D + 1);
      chk("b2b_period2", del_t[2] - del_t[1], D + 1);
    end
    chk("b2b_block2", last_block, 128'h2F2E2D2C2B2A29282726252423222120);
    s_valid = 0; p_ready = 0;
    cyc();

`ifdef AES_SHIFT_REG_DRAIN_EN
    // Load with a competing serial offer, then drain.
    l_valid = 1; s_valid = 1; s_data = 8'h99;
    l_data = 128'h0F0E0D0C0B0A09080706050403020100;
    cyc();
    l_valid = 0; s_valid = 0; d_ready = 1;
    for (int i = 0; i < D; i++) begin
      #1;
      chk("drain_elem", d_data, 8'(i));
      #1;
      cyc();
    end
    d_ready = 0;
    #1;
    chk("drain_l_ready", l_ready, 1);
    chk("drain_d_valid", d_valid, 0);
    #1;
    cyc();
`else
    // l_valid held high must not disturb a serial fill in this build.
    l_valid = 1; l_data = {PW{1'b1}}; d_ready = 1;
    s_valid = 1; s_data = 8'h55;
    for (int i = 0; i < D; i++) cyc();
    #1;
    chk("nodrn_p_data", p_data, {D{8'h55}});
    chk("nodrn_l_ready", l_ready, 0);
    chk("nodrn_d_valid", d_valid, 0);
    #1;
    p_ready = 1; s_valid = 0;
    cyc();
    p_ready = 0; l_valid = 0; d_ready = 0;
`endif

    // Partial fill, then flush.
    s_valid = 1;
    for (int i = 0; i < 7; i++) begin
      s_data = 8'h30 + 8'(i);
      cyc();
    end
    flush = 1; s_data = 8'h77;
    cyc();
    flush = 0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_p_data", p_data, 0);
    #1;
    for (int i = 0; i < D; i++) begin
      s_data = 8'hA0 + 8'(i);
      cyc();
    end
    #1;
    chk("refill_p_data", p_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    #1;
    s_valid = 0; p_ready = 1;
    cyc();
    p_ready = 0;

    // Asynchronous reset with 9 elements held.
`ifdef AES_SHIFT_REG_DRAIN_EN
    l_valid = 1;
    l_data = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    l_valid = 0; d_ready = 1;
    for (int i = 0; i < 7; i++) cyc();
    d_ready = 0;
`else
    s_valid = 1;
    for (int i = 0; i < 9; i++) begin
      s_data = 8'($urandom);
      cyc();
    end
    s_valid = 0;
`endif
    #1;
    chk("pre_rst_count", count, 9);
    rst = 1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_p_data", p_data, 0);
    chk("arst_d_data", d_data, 0);
    chk("arst_d_valid", d_valid, 0);
    q.delete(); mode = M_FILL;
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    #1;
    cyc();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      flush   = ($urandom_range(0, 40) == 0);
      s_valid = $urandom_range(0, 3) != 0;
      s_data  = 8'($urandom);
      p_ready = $urandom_range(0, 2) == 0;
      l_valid = $urandom_range(0, 7) == 0;
      l_data  = {$urandom, $urandom, $urandom, $urandom};
      d_ready = $urandom_range(0, 2) != 0;
      cyc();
    end
    idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
